// File: rtl/pipeline_pkg.sv
// Shared pipeline constants for the fetch stage, ID stage and hazard unit.
package pipeline_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding prefetched {pc, instruction} entries between fetch and IF/ID.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  logic [W-1:0]  data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is only legal when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage: PC register, prefetch queue and IF/ID register, so decode stalls do not freeze fetch.
module if_stage_prefetch
  import pipeline_pkg::*;
#(
  parameter  int             N        = XLEN,
  parameter  int             ADDR_W   = 8,
  parameter  int             DEPTH    = 4,
  parameter  logic [N-1:0]   RESET_PC = N'(DEFAULT_RESET_PC),
  localparam int             CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [N-1:0]      redirect_pc,
  input  logic              if_id_write,
  input  logic              if_flush,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [N-1:0]      imem_data,
  output logic [N-1:0]      instruction,
  output logic [N-1:0]      npc,
  output logic              inst_valid,
  output logic [CW-1:0]     q_count
);

  logic [N-1:0]   pc_q, pc_d;
  logic [N-1:0]   instr_q, instr_d;
  logic [N-1:0]   npc_q, npc_d;
  logic           valid_q, valid_d;
  logic           push, pop;
  logic           q_full, q_empty;
  logic [2*N-1:0] q_head;

  // A redirect kills the whole wrong path, including anything that would move this edge.
  assign pop  = if_id_write && !if_flush && !redirect_valid && !q_empty;
  assign push = !redirect_valid && (!q_full || pop);

  fetch_queue #(
    .W     (2 * N),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect_valid),
    .data_i  ({pc_q, imem_data}),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count),
    .head_o  (q_head)
  );

  assign imem_addr   = pc_q[ADDR_W-1:0];
  assign instruction = instr_q;
  assign npc         = npc_q;
  assign inst_valid  = valid_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc;
    else if (push)      pc_d = pc_q + N'(1);
  end

  // Flush wins over stall; an empty queue with the register open inserts a bubble.
  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (if_flush) begin
      instr_d = N'(NOP_INSTR);
      valid_d = 1'b0;
    end else if (if_id_write) begin
      if (pop) begin
        instr_d = q_head[N-1:0];
        npc_d   = q_head[2*N-1:N];
        valid_d = 1'b1;
      end else begin
        instr_d = N'(NOP_INSTR);
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Bench for if_stage_prefetch: directed vector table, hand-written corner sequence, then random traffic against a queue-based model.
module tb_if_stage_prefetch;

  localparam int          N      = 32;
  localparam int          ADDR_W = 8;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RPC    = 32'h0;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        w;
    logic        f;
    logic [7:0]  expAddr;
    int          expCount;
    logic        expValid;
    logic [31:0] expNpc;
    logic [31:0] expInstr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic              clk;
  logic              reset;
  logic              redirect_valid;
  logic [N-1:0]      redirect_pc;
  logic              if_id_write;
  logic              if_flush;
  logic [ADDR_W-1:0] imem_addr;
  logic [N-1:0]      imem_data;
  logic [N-1:0]      instruction;
  logic [N-1:0]      npc;
  logic              inst_valid;
  logic [2:0]        q_count;

  logic [31:0] mem [256];

  logic [31:0] mPc, mInstr, mNpc;
  logic        mValid;
  entry_t      mQ[$];

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  if_stage_prefetch #(
    .N        (N),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_write    (if_id_write),
    .if_flush       (if_flush),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instruction    (instruction),
    .npc            (npc),
    .inst_valid     (inst_valid),
    .q_count        (q_count)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference behaviour: a plain FIFO of {address, word} pairs fed by a free-running PC.
  task automatic modelStep();
    int     sizeBefore;
    logic   canPop;
    entry_t e;
    if (reset) begin
      mPc    = RPC;
      mQ.delete();
      mInstr = 32'h0;
      mNpc   = 32'h0;
      mValid = 1'b0;
    end else begin
      sizeBefore = mQ.size();
      canPop     = if_id_write && !if_flush && !redirect_valid && (sizeBefore > 0);
      if (if_flush) begin
        mInstr = 32'h0;
        mValid = 1'b0;
      end else if (if_id_write) begin
        if (canPop) begin
          e      = mQ.pop_front();
          mInstr = e.instr;
          mNpc   = e.pc;
          mValid = 1'b1;
        end else begin
          mInstr = 32'h0;
          mValid = 1'b0;
        end
      end
      if (redirect_valid) begin
        mQ.delete();
        mPc = redirect_pc;
      end else if (sizeBefore < DEPTH || canPop) begin
        e.pc    = mPc;
        e.instr = mem[mPc[7:0]];
        mQ.push_back(e);
        mPc = mPc + 32'd1;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] rpc,
                               input logic w, input logic f);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_id_write    = w;
    if_flush       = f;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkVal(input string name, input int step, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, step, got, exp);
    end
  endtask

  task automatic checkOutput(input int step);
    checkVal("model_addr",  step, 32'(imem_addr),   {24'h0, mPc[7:0]});
    checkVal("model_count", step, 32'(q_count),     32'(mQ.size()));
    checkVal("model_valid", step, 32'(inst_valid),  32'(mValid));
    checkVal("model_npc",   step, npc,              mNpc);
    checkVal("model_instr", step, instruction,      mInstr);
  endtask

  function automatic void addVec(input logic rst, input logic rv, input logic [31:0] rpc,
                                 input logic w, input logic f, input logic [7:0] a, input int c,
                                 input logic v, input logic [31:0] n, input logic [31:0] i);
    vec_t t;
    t.rst = rst; t.rv = rv; t.rpc = rpc; t.w = w; t.f = f;
    t.expAddr = a; t.expCount = c; t.expValid = v; t.expNpc = n; t.expInstr = i;
    vecs.push_back(t);
  endfunction

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_id_write = 1'b0; if_flush = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + 32'(i);
    mPc = RPC; mInstr = '0; mNpc = '0; mValid = 1'b0;

    // Reset then free run
    addVec(1,0,0,1,0, 8'h00,0,0,32'h0,32'h0);
    addVec(0,0,0,1,0, 8'h01,1,0,32'h0,32'h0);
    addVec(0,0,0,1,0, 8'h02,1,1,32'h0,32'h1000);
    addVec(0,0,0,1,0, 8'h03,1,1,32'h1,32'h1001);
    addVec(0,0,0,1,0, 8'h04,1,1,32'h2,32'h1002);
    // Stall fill: queue reaches DEPTH then the PC freezes
    addVec(0,0,0,0,0, 8'h05,2,1,32'h2,32'h1002);
    addVec(0,0,0,0,0, 8'h06,3,1,32'h2,32'h1002);
    addVec(0,0,0,0,0, 8'h07,4,1,32'h2,32'h1002);
    addVec(0,0,0,0,0, 8'h07,4,1,32'h2,32'h1002);
    addVec(0,0,0,0,0, 8'h07,4,1,32'h2,32'h1002);
    addVec(0,0,0,0,0, 8'h07,4,1,32'h2,32'h1002);
    // Release: full queue pushes and pops together
    addVec(0,0,0,1,0, 8'h08,4,1,32'h3,32'h1003);
    addVec(0,0,0,1,0, 8'h09,4,1,32'h4,32'h1004);
    addVec(0,0,0,1,0, 8'h0a,4,1,32'h5,32'h1005);
    addVec(0,0,0,1,0, 8'h0b,4,1,32'h6,32'h1006);
    addVec(0,0,0,1,0, 8'h0c,4,1,32'h7,32'h1007);
    // Flush during stall, then reset during stall with a full queue
    addVec(0,0,0,0,1, 8'h0c,4,0,32'h7,32'h0);
    addVec(1,0,0,0,0, 8'h00,0,0,32'h0,32'h0);
    addVec(0,0,0,1,0, 8'h01,1,0,32'h0,32'h0);
    addVec(0,0,0,1,0, 8'h02,1,1,32'h0,32'h1000);
    addVec(0,0,0,1,0, 8'h03,1,1,32'h1,32'h1001);
    // Build 3 entries, then redirect
    addVec(0,0,0,0,0, 8'h04,2,1,32'h1,32'h1001);
    addVec(0,0,0,0,0, 8'h05,3,1,32'h1,32'h1001);
    addVec(0,1,32'h40,1,0, 8'h40,0,0,32'h1,32'h0);
    addVec(0,0,0,1,0, 8'h41,1,0,32'h1,32'h0);
    addVec(0,0,0,1,0, 8'h42,1,1,32'h40,32'h1040);
    addVec(0,0,0,1,0, 8'h43,1,1,32'h41,32'h1041);
    // PC wrap from all-ones to zero
    addVec(0,1,32'hFFFF_FFFF,1,0, 8'hff,0,0,32'h41,32'h0);
    addVec(0,0,0,1,0, 8'h00,1,0,32'h41,32'h0);
    addVec(0,0,0,1,0, 8'h01,1,1,32'hFFFF_FFFF,32'h10ff);
    addVec(0,0,0,1,0, 8'h02,1,1,32'h0,32'h1000);

    @(negedge clk);
    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].rst, vecs[k].rv, vecs[k].rpc, vecs[k].w, vecs[k].f);
      checkVal("addr",  k, 32'(imem_addr),  {24'h0, vecs[k].expAddr});
      checkVal("count", k, 32'(q_count),    32'(vecs[k].expCount));
      checkVal("valid", k, 32'(inst_valid), 32'(vecs[k].expValid));
      checkVal("npc",   k, npc,             vecs[k].expNpc);
      checkVal("instr", k, instruction,     vecs[k].expInstr);
      checkOutput(k);
    end

    // Redirect while decode is stalled: IF/ID holds, queue refills, target arrives on release
    applyStimulus(0, 1, 32'h80, 0, 0);
    checkVal("stallredir_valid", 100, 32'(inst_valid), 32'h1);
    checkVal("stallredir_npc",   100, npc,              32'h0);
    checkVal("stallredir_count", 100, 32'(q_count),     32'h0);
    checkVal("stallredir_addr",  100, 32'(imem_addr),   32'h80);
    applyStimulus(0, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0);
    checkVal("stallredir_hold",  101, instruction,      32'h1000);
    checkVal("stallredir_fill",  101, 32'(q_count),     32'h2);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkVal("stallredir_tnpc",  102, npc,              32'h80);
    checkVal("stallredir_tins",  102, instruction,      32'h1080);
    checkVal("stallredir_tval",  102, 32'(inst_valid),  32'h1);
    checkOutput(102);

    // Random traffic with random memory contents
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int k = 0; k < 600; k++) begin
      logic        rst, rv, w, f;
      logic [31:0] rpc;
      rst = ($urandom_range(0, 59) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = {($urandom_range(0, 3) == 0) ? 24'hFF_FFFF : 24'h0, 8'($urandom_range(0, 255))};
      w   = ($urandom_range(0, 9) < 6);
      f   = ($urandom_range(0, 11) == 0);
      applyStimulus(rst, rv, rpc, w, f);
      checkOutput(1000 + k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
